// File: rtl/bloom_rmw_ctrl_pkg.sv
// Shared definitions for the Bloom filter read-modify-write controller.
//   - default row geometry (field offsets, widths, tick period)
//   - FSM state encoding used by bloom_rmw_ctrl
//   - log2c(): ceiling log2 for deriving counter/index widths
// Optional feature macro: BLOOM_RMW_STATS_EN (see bloom_rmw_ctrl.sv).
package bloom_rmw_ctrl_pkg;

  // Default SRAM row layout: bloom[71:16] | bucket stamp | loop stamp
  localparam int DEF_DATA_WIDTH       = 72;
  localparam int DEF_NUM_BUCKETS      = 12;
  localparam int DEF_BUCKET_SZ        = 4;
  localparam int DEF_BITS_SHIFT       = 4;
  localparam int DEF_BLOOM_INIT_POS   = 16;
  localparam int DEF_ADDR_WIDTH       = 19;
  localparam int DEF_TICKS_PER_BUCKET = 1000000;
  localparam int DEF_LOOP_W           = DEF_BLOOM_INIT_POS - DEF_BITS_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_AGE     = 3'd3,
    ST_WR      = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Smallest r with 2**r >= v (v >= 2 in every use here).
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bloom_rmw_ctrl_if.sv
// Request / SRAM / response bundle of the Bloom RMW controller.
//   master : controller side (accepts requests, drives SRAM commands, responds)
//   slave  : environment side (request source, SRAM model, response sink)
// Signals: req_valid/req_ready/req_addr/req_insert/req_bit,
//          sram_req/sram_wr/sram_addr/sram_wr_data/sram_ack/sram_rd_vld/sram_rd_data,
//          resp_valid/resp_hit/resp_addr.
interface bloom_rmw_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 72,
  parameter int BIT_W      = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_insert;
  logic [BIT_W-1:0]      req_bit;

  logic                  sram_req;
  logic                  sram_wr;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wr_data;
  logic                  sram_ack;
  logic                  sram_rd_vld;
  logic [DATA_WIDTH-1:0] sram_rd_data;

  logic                  resp_valid;
  logic                  resp_hit;
  logic [ADDR_WIDTH-1:0] resp_addr;

  modport master (
    input  req_valid, req_addr, req_insert, req_bit,
    input  sram_ack, sram_rd_vld, sram_rd_data,
    output req_ready,
    output sram_req, sram_wr, sram_addr, sram_wr_data,
    output resp_valid, resp_hit, resp_addr
  );

  modport slave (
    output req_valid, req_addr, req_insert, req_bit,
    output sram_ack, sram_rd_vld, sram_rd_data,
    input  req_ready,
    input  sram_req, sram_wr, sram_addr, sram_wr_data,
    input  resp_valid, resp_hit, resp_addr
  );
endinterface

// File: rtl/bloom_rmw_ctrl_time_base.sv
// bloom_time_base: bucket/loop time base of the sliding Bloom filter.
//   clk, reset       : clock, synchronous active-high reset
//   cur_bucket [BS]  : bucket counter 0..NUM_BUCKETS-1, advances every TICKS_PER_BUCKET cycles
//   cur_loop   [LW]  : loop counter, +1 when the bucket counter wraps, wraps mod 2^LOOP_W
module bloom_time_base
  import bloom_rmw_ctrl_pkg::*;
#(
  parameter int NUM_BUCKETS      = DEF_NUM_BUCKETS,
  parameter int BITS_SHIFT       = DEF_BITS_SHIFT,
  parameter int LOOP_W           = DEF_LOOP_W,
  parameter int TICKS_PER_BUCKET = DEF_TICKS_PER_BUCKET
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [BITS_SHIFT-1:0] cur_bucket,
  output logic [LOOP_W-1:0]     cur_loop
);
  localparam int TICK_W = log2c(TICKS_PER_BUCKET);

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BITS_SHIFT-1:0] bucket_q, bucket_d;
  logic [LOOP_W-1:0]     loop_q, loop_d;

  always_comb begin
    tick_d   = tick_q + 1'b1;
    bucket_d = bucket_q;
    loop_d   = loop_q;
    if (tick_q == TICK_W'(TICKS_PER_BUCKET - 1)) begin
      tick_d = '0;
      if (bucket_q == BITS_SHIFT'(NUM_BUCKETS - 1)) begin
        bucket_d = '0;
        loop_d   = loop_q + 1'b1;   // natural wrap mod 2^LOOP_W
      end else begin
        bucket_d = bucket_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q   <= '0;
      bucket_q <= '0;
      loop_q   <= '0;
    end else begin
      tick_q   <= tick_d;
      bucket_q <= bucket_d;
      loop_q   <= loop_d;
    end
  end

  assign cur_bucket = bucket_q;
  assign cur_loop   = loop_q;
endmodule

// File: rtl/bloom_rmw_ctrl.sv
// bloom_rmw_ctrl: read-modify-write controller for the time-sliding Bloom
// filter held in off-chip SRAM.
//   clk, reset        : clock, synchronous active-high reset
//   bus (master)      : request accept, SRAM read/write commands, hit/miss response
//   age_row_out       : row read from SRAM, handed to the external aging stage
//   age_cur_bucket/
//   age_cur_loop      : time stamp snapshotted when the request was accepted
//   age_row_in        : aged row returned combinationally by the aging stage
//   cur_bucket/cur_loop : live time base
// Optional build macro BLOOM_RMW_STATS_EN adds stat_inserts, stat_queries,
// stat_hits (32-bit saturating counters bumped once per response).
module bloom_rmw_ctrl
  import bloom_rmw_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int NUM_BUCKETS      = DEF_NUM_BUCKETS,
  parameter int BUCKET_SZ        = DEF_BUCKET_SZ,
  parameter int BITS_SHIFT       = DEF_BITS_SHIFT,
  parameter int BLOOM_INIT_POS   = DEF_BLOOM_INIT_POS,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int TICKS_PER_BUCKET = DEF_TICKS_PER_BUCKET,
  localparam int LOOP_W          = BLOOM_INIT_POS - BITS_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  bloom_rmw_if.master           bus,
  output logic [DATA_WIDTH-1:0] age_row_out,
  output logic [BITS_SHIFT-1:0] age_cur_bucket,
  output logic [LOOP_W-1:0]     age_cur_loop,
  input  logic [DATA_WIDTH-1:0] age_row_in,
  output logic [BITS_SHIFT-1:0] cur_bucket,
  output logic [LOOP_W-1:0]     cur_loop
`ifdef BLOOM_RMW_STATS_EN
  ,
  output logic [31:0]           stat_inserts,
  output logic [31:0]           stat_queries,
  output logic [31:0]           stat_hits
`endif
);
  localparam int BIT_W = log2c(BUCKET_SZ);
  // Every bucket-wide slot of the bloom field takes part in the hit test.
  localparam int FIELD_BUCKETS = (DATA_WIDTH - BLOOM_INIT_POS) / BUCKET_SZ;
  localparam int NEWEST_LSB    = DATA_WIDTH - BUCKET_SZ;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  insert_q, insert_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [BITS_SHIFT-1:0] snap_bucket_q, snap_bucket_d;
  logic [LOOP_W-1:0]     snap_loop_q, snap_loop_d;
  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  hit_q, hit_d;

  bloom_time_base #(
    .NUM_BUCKETS      (NUM_BUCKETS),
    .BITS_SHIFT       (BITS_SHIFT),
    .LOOP_W           (LOOP_W),
    .TICKS_PER_BUCKET (TICKS_PER_BUCKET)
  ) u_time_base (
    .clk        (clk),
    .reset      (reset),
    .cur_bucket (cur_bucket),
    .cur_loop   (cur_loop)
  );

  // Hit test on the aged row, before the insert bit is applied.
  logic [FIELD_BUCKETS-1:0] hit_vec;
  for (genvar gi = 0; gi < FIELD_BUCKETS; gi++) begin : g_hit
    logic [BUCKET_SZ-1:0] bkt;
    assign bkt         = age_row_in[BLOOM_INIT_POS + gi*BUCKET_SZ +: BUCKET_SZ];
    assign hit_vec[gi] = bkt[bit_q];
  end

  // Write-back row: aged row, plus the requested bit in the newest bucket on insert.
  logic [BUCKET_SZ-1:0]  ins_mask;
  logic [DATA_WIDTH-1:0] wr_row;
  always_comb begin
    ins_mask = BUCKET_SZ'(1) << bit_q;
    wr_row   = age_row_in;
    if (insert_q) begin
      wr_row[NEWEST_LSB +: BUCKET_SZ] = age_row_in[NEWEST_LSB +: BUCKET_SZ] | ins_mask;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    insert_d      = insert_q;
    bit_d         = bit_q;
    snap_bucket_d = snap_bucket_q;
    snap_loop_d   = snap_loop_q;
    row_d         = row_q;
    wr_data_d     = wr_data_q;
    hit_d         = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d       = ST_RD;
          addr_d        = bus.req_addr;
          insert_d      = bus.req_insert;
          bit_d         = bus.req_bit;
          // Time stamp is frozen here for the whole operation.
          snap_bucket_d = cur_bucket;
          snap_loop_d   = cur_loop;
        end
      end
      ST_RD: begin
        if (bus.sram_ack) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.sram_rd_vld) begin
          row_d   = bus.sram_rd_data;
          state_d = ST_AGE;
        end
      end
      ST_AGE: begin
        // age_row_in is valid this cycle; register both results of the aging stage.
        wr_data_d = wr_row;
        hit_d     = |hit_vec;
        state_d   = ST_WR;
      end
      ST_WR: begin
        if (bus.sram_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      insert_q      <= 1'b0;
      bit_q         <= '0;
      snap_bucket_q <= '0;
      snap_loop_q   <= '0;
      row_q         <= '0;
      wr_data_q     <= '0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      insert_q      <= insert_d;
      bit_q         <= bit_d;
      snap_bucket_q <= snap_bucket_d;
      snap_loop_q   <= snap_loop_d;
      row_q         <= row_d;
      wr_data_q     <= wr_data_d;
      hit_q         <= hit_d;
    end
  end

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.sram_req     = (state_q == ST_RD) || (state_q == ST_WR);
  assign bus.sram_wr      = (state_q == ST_WR);
  assign bus.sram_addr    = addr_q;
  assign bus.sram_wr_data = wr_data_q;
  assign bus.resp_valid   = (state_q == ST_RESP);
  assign bus.resp_hit     = hit_q;
  assign bus.resp_addr    = addr_q;

  assign age_row_out    = row_q;
  assign age_cur_bucket = snap_bucket_q;
  assign age_cur_loop   = snap_loop_q;

`ifdef BLOOM_RMW_STATS_EN
  logic [31:0] ins_cnt_q, ins_cnt_d;
  logic [31:0] qry_cnt_q, qry_cnt_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    ins_cnt_d = ins_cnt_q;
    qry_cnt_d = qry_cnt_q;
    hit_cnt_d = hit_cnt_q;
    if (state_q == ST_RESP) begin
      if (insert_q  && (ins_cnt_q != '1)) ins_cnt_d = ins_cnt_q + 1'b1;
      if (!insert_q && (qry_cnt_q != '1)) qry_cnt_d = qry_cnt_q + 1'b1;
      if (hit_q     && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ins_cnt_q <= '0;
      qry_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      ins_cnt_q <= ins_cnt_d;
      qry_cnt_q <= qry_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign stat_inserts = ins_cnt_q;
  assign stat_queries = qry_cnt_q;
  assign stat_hits    = hit_cnt_q;
`endif
endmodule

// File: tb/tb_bloom_rmw_ctrl.sv
// Directed self-checking bench for bloom_rmw_ctrl (TICKS_PER_BUCKET = 4).
module tb_bloom_rmw_ctrl;
  localparam int DW  = 72;
  localparam int AW  = 19;
  localparam int BW  = 2;
  localparam int LW  = 12;
  localparam int TPB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bloom_rmw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_W(BW)) bus ();

  logic [DW-1:0] age_row_out, age_row_in, age_xor;
  logic [3:0]    age_cur_bucket, cur_bucket;
  logic [LW-1:0] age_cur_loop, cur_loop;

  // Aging stage model: passthrough, optionally flipping bits.
  assign age_row_in = age_row_out ^ age_xor;

`ifdef BLOOM_RMW_STATS_EN
  logic [31:0] stat_inserts, stat_queries, stat_hits;
`endif

  bloom_rmw_ctrl #(.TICKS_PER_BUCKET(TPB)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .age_row_out    (age_row_out),
    .age_cur_bucket (age_cur_bucket),
    .age_cur_loop   (age_cur_loop),
    .age_row_in     (age_row_in),
    .cur_bucket     (cur_bucket),
    .cur_loop       (cur_loop)
`ifdef BLOOM_RMW_STATS_EN
    ,
    .stat_inserts   (stat_inserts),
    .stat_queries   (stat_queries),
    .stat_hits      (stat_hits)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Observations of the last run_op.
  int            lat, resp_cnt, stall_err, busy_ready_err;
  logic          timeout, hit_seen;
  logic [AW-1:0] resp_addr_seen, rd_addr_seen, wr_addr_seen;
  logic [DW-1:0] wr_data_seen;
  logic [3:0]    snap_b_seen, live_b_seen;
  logic [LW-1:0] snap_l_seen, live_l_seen;

  // Drives one request and plays the SRAM; must be called at a negedge.
  task automatic run_op(input logic [AW-1:0] a, input logic ins, input logic [BW-1:0] b,
                        input logic [DW-1:0] row, input int rd_dly, input int wr_dly);
    int w, cyc, wait_cnt, post;
    logic rd_pending, in_cmd, ref_wr;
    logic [AW-1:0] ref_addr;
    logic [DW-1:0] ref_data;
    lat = -1; resp_cnt = 0; stall_err = 0; busy_ready_err = 0; timeout = 1'b0;
    hit_seen = 1'bx; wr_data_seen = 'x; rd_addr_seen = 'x; wr_addr_seen = 'x; resp_addr_seen = 'x;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_insert = ins; bus.req_bit = b;
    w = 0;
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1; wait_cnt = 0; post = 0; rd_pending = 1'b0; in_cmd = 1'b0;
    ref_wr = 1'b0; ref_addr = '0; ref_data = '0;
    for (int i = 0; i < 200; i++) begin
      bus.sram_ack = 1'b0; bus.sram_rd_vld = 1'b0;
      if (rd_pending) begin bus.sram_rd_vld = 1'b1; bus.sram_rd_data = row; rd_pending = 1'b0; end
      if (bus.sram_req) begin
        if (!in_cmd) begin
          in_cmd = 1'b1; wait_cnt = 0;
          ref_wr = bus.sram_wr; ref_addr = bus.sram_addr; ref_data = bus.sram_wr_data;
        end else if (bus.sram_wr !== ref_wr || bus.sram_addr !== ref_addr || bus.sram_wr_data !== ref_data) begin
          stall_err++;
        end
        if (wait_cnt == (bus.sram_wr ? wr_dly : rd_dly)) begin
          bus.sram_ack = 1'b1; in_cmd = 1'b0;
          if (bus.sram_wr) begin wr_data_seen = bus.sram_wr_data; wr_addr_seen = bus.sram_addr; end
          else begin rd_addr_seen = bus.sram_addr; rd_pending = 1'b1; end
        end else begin
          wait_cnt++;
        end
      end
      if (resp_cnt == 0 && bus.req_ready) busy_ready_err++;
      if (bus.resp_valid) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          lat = cyc; hit_seen = bus.resp_hit; resp_addr_seen = bus.resp_addr;
          snap_b_seen = age_cur_bucket; snap_l_seen = age_cur_loop;
          live_b_seen = cur_bucket; live_l_seen = cur_loop;
        end
      end
      if (resp_cnt > 0) post++;
      if (post >= 4) break;
      @(negedge clk); cyc++;
    end
    bus.sram_ack = 1'b0; bus.sram_rd_vld = 1'b0;
    if (resp_cnt == 0) timeout = 1'b1;
    $display("op addr=%h ins=%0b bit=%0d lat=%0d hit=%0b wr_data=%h resp_cnt=%0d",
             a, ins, b, lat, hit_seen, wr_data_seen, resp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int ready_err;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.sram_req !== 1'b0 || bus.sram_wr !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outs got req=%b wr=%b resp=%b exp=0", bus.sram_req, bus.sram_wr, bus.resp_valid); end
    checks++; if (cur_bucket !== 4'd0 || cur_loop !== 12'd0) begin
      errors++; $display("FAIL reset_time got b=%0d l=%0d exp=0/0", cur_bucket, cur_loop); end
    reset = 1'b0;
    ready_err = 0;
    for (int i = 0; i < 3*TPB; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b1) ready_err++;
    end
    checks++; if (ready_err != 0) begin errors++; $display("FAIL idle_ready got errs=%0d exp=0", ready_err); end
    checks++; if (cur_bucket !== 4'd3 || cur_loop !== 12'd0) begin
      errors++; $display("FAIL idle_time got b=%0d l=%0d exp=3/0", cur_bucket, cur_loop); end
    $display("reset/idle: cur_bucket=%0d cur_loop=%0d", cur_bucket, cur_loop);
  endtask

  task automatic test_insert();
    run_op(19'h10, 1'b1, 2'd2, 72'h0, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ins_timeout got=%b exp=0", timeout); end
    checks++; if (lat != 5) begin errors++; $display("FAIL ins_latency got=%0d exp=5", lat); end
    checks++; if (wr_data_seen !== 72'h400000000000000000) begin
      errors++; $display("FAIL ins_wr_data got=%h exp=400000000000000000", wr_data_seen); end
    checks++; if (hit_seen !== 1'b0) begin errors++; $display("FAIL ins_hit got=%b exp=0", hit_seen); end
    checks++; if (rd_addr_seen !== 19'h10 || wr_addr_seen !== 19'h10 || resp_addr_seen !== 19'h10) begin
      errors++; $display("FAIL ins_addr got rd=%h wr=%h resp=%h exp=10", rd_addr_seen, wr_addr_seen, resp_addr_seen); end
    checks++; if (resp_cnt != 1 || busy_ready_err != 0) begin
      errors++; $display("FAIL ins_pulse got resp_cnt=%0d ready_errs=%0d exp=1/0", resp_cnt, busy_ready_err); end
  endtask

  task automatic test_query();
    run_op(19'h10, 1'b0, 2'd2, 72'h40000, 0, 0);
    checks++; if (hit_seen !== 1'b1) begin errors++; $display("FAIL qry_hit got=%b exp=1", hit_seen); end
    checks++; if (wr_data_seen !== 72'h40000) begin errors++; $display("FAIL qry_wr_data got=%h exp=40000", wr_data_seen); end
    // Same row, other bit index: miss.
    run_op(19'h11, 1'b0, 2'd1, 72'h40000, 0, 0);
    checks++; if (hit_seen !== 1'b0) begin errors++; $display("FAIL qry_miss_bit got=%b exp=0", hit_seen); end
    // Set bit in a middle bucket (bucket 5, bit 2 -> row bit 38): hit.
    run_op(19'h12, 1'b0, 2'd2, 72'h4000000000, 0, 0);
    checks++; if (hit_seen !== 1'b1) begin errors++; $display("FAIL qry_mid_bucket got=%b exp=1", hit_seen); end
    // Only stamp bits set: never a hit.
    run_op(19'h13, 1'b0, 2'd0, 72'hFFFF, 0, 0);
    checks++; if (hit_seen !== 1'b0 || wr_data_seen !== 72'hFFFF) begin
      errors++; $display("FAIL qry_stamp_only got hit=%b wr=%h exp=0/ffff", hit_seen, wr_data_seen); end
  endtask

  task automatic test_aging();
    // Aging clears the only set bit: hit and write-back follow the aged row.
    age_xor = 72'h40000;
    run_op(19'h20, 1'b0, 2'd2, 72'h40000, 0, 0);
    checks++; if (hit_seen !== 1'b0 || wr_data_seen !== 72'h0) begin
      errors++; $display("FAIL age_clear got hit=%b wr=%h exp=0/0", hit_seen, wr_data_seen); end
    age_xor = 72'h1234;
    run_op(19'h21, 1'b1, 2'd0, 72'h0, 0, 0);
    checks++; if (hit_seen !== 1'b0 || wr_data_seen !== 72'h100000000000001234) begin
      errors++; $display("FAIL age_insert got hit=%b wr=%h exp=0/100000000000001234", hit_seen, wr_data_seen); end
    age_xor = '0;
  endtask

  task automatic test_bucket_wrap();
    do_reset();
    repeat (11*TPB) @(negedge clk);
    checks++; if (cur_bucket !== 4'd11 || cur_loop !== 12'd0) begin
      errors++; $display("FAIL wrap_pre got b=%0d l=%0d exp=11/0", cur_bucket, cur_loop); end
    run_op(19'h30, 1'b0, 2'd3, 72'h0, 0, 0);
    checks++; if (snap_b_seen !== 4'd11 || snap_l_seen !== 12'd0) begin
      errors++; $display("FAIL wrap_snapshot got b=%0d l=%0d exp=11/0", snap_b_seen, snap_l_seen); end
    checks++; if (live_b_seen !== 4'd0 || live_l_seen !== 12'd1) begin
      errors++; $display("FAIL wrap_live got b=%0d l=%0d exp=0/1", live_b_seen, live_l_seen); end
  endtask

  task automatic test_stall();
    run_op(19'h5A5A, 1'b1, 2'd3, 72'hABCD, 7, 7);
    checks++; if (lat != 19) begin errors++; $display("FAIL stall_latency got=%0d exp=19", lat); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stable got errs=%0d exp=0", stall_err); end
    checks++; if (resp_cnt != 1) begin errors++; $display("FAIL stall_pulse got=%0d exp=1", resp_cnt); end
    checks++; if (wr_data_seen !== 72'h80000000000000ABCD || wr_addr_seen !== 19'h5A5A) begin
      errors++; $display("FAIL stall_wr got data=%h addr=%h exp=80000000000000abcd/5a5a", wr_data_seen, wr_addr_seen); end
  endtask

  task automatic test_reset_mid_op();
    int bad;
    bus.req_valid = 1'b1; bus.req_addr = 19'h77; bus.req_insert = 1'b1; bus.req_bit = 2'd1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.sram_ack = 1'b1;               // RD: accept the read immediately
    @(negedge clk);
    bus.sram_ack = 1'b0;               // now in RD_WAIT
    checks++; if (bus.sram_req !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rdwait got req=%b ready=%b exp=0/0", bus.sram_req, bus.req_ready); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.req_ready !== 1'b1 || bus.sram_req !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after_reset got ready=%b req=%b resp=%b exp=1/0/0", bus.req_ready, bus.sram_req, bus.resp_valid); end
    checks++; if (cur_bucket !== 4'd0 || cur_loop !== 12'd0) begin
      errors++; $display("FAIL mid_counters got b=%0d l=%0d exp=0/0", cur_bucket, cur_loop); end
    bus.sram_rd_vld = 1'b1; bus.sram_rd_data = 72'hFFFF_FFFF_FFFF_FFFF_FF;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.sram_rd_vld = 1'b0;
      if (bus.resp_valid !== 1'b0 || bus.sram_req !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_stray_rdvld got bad=%0d exp=0", bad); end
    // Controller still works after the dropped op.
    run_op(19'h33, 1'b0, 2'd0, 72'h10000, 0, 0);
    checks++; if (hit_seen !== 1'b1 || lat != 5 || resp_cnt != 1) begin
      errors++; $display("FAIL mid_recover got hit=%b lat=%0d cnt=%0d exp=1/5/1", hit_seen, lat, resp_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_insert = 1'b0; bus.req_bit = '0;
    bus.sram_ack = 1'b0; bus.sram_rd_vld = 1'b0; bus.sram_rd_data = '0;
    age_xor = '0;
    test_reset();
    test_insert();
    test_query();
    test_aging();
    test_bucket_wrap();
    test_stall();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
